// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the pipelined ALU.
//   - op_t and opcode constants OP_NOP..OP_MOV (4-bit opcode field)
//   - PSW bit positions within the 3-bit {N, Z, C} status word
package alu_pipe_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_NOP = 4'd0;
    localparam op_t OP_ADD = 4'd1;
    localparam op_t OP_SUB = 4'd2;
    localparam op_t OP_AND = 4'd3;
    localparam op_t OP_OR  = 4'd4;
    localparam op_t OP_XOR = 4'd5;
    localparam op_t OP_NOT = 4'd6;
    localparam op_t OP_SHL = 4'd7;
    localparam op_t OP_SHR = 4'd8;
    localparam op_t OP_SAR = 4'd9;
    localparam op_t OP_ROL = 4'd10;
    localparam op_t OP_ROR = 4'd11;
    localparam op_t OP_ADC = 4'd12;
    localparam op_t OP_SBB = 4'd13;
    localparam op_t OP_CMP = 4'd14;
    localparam op_t OP_MOV = 4'd15;

    localparam int unsigned PSW_N = 2;
    localparam int unsigned PSW_Z = 1;
    localparam int unsigned PSW_C = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: purely combinational ALU datapath.
//   op      - opcode
//   a, b    - operands (src1, src2)
//   shamt   - immediate shift/rotate amount (taken modulo WIDTH)
//   cin     - carry/borrow in for ADC/SBB
//   result  - WIDTH-bit result
//   n, z, c - flags derived from this operation
//   c_upd   - high when this op defines a new carry flag
//   wr_en   - high when the result is written to the register file
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 4
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    shamt,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             c_upd,
    output logic             wr_en
);

    logic [31:0]    w_sh;
    logic [WIDTH:0] w_cin_ext;

    assign w_sh      = 32'(shamt) % 32'(WIDTH);
    assign w_cin_ext = {{WIDTH{1'b0}}, cin};

    always_comb begin
        result = '0;
        c      = 1'b0;
        c_upd  = 1'b0;
        case (op)
            OP_ADD: begin
                {c, result} = {1'b0, a} + {1'b0, b};
                c_upd       = 1'b1;
            end
            OP_ADC: begin
                {c, result} = {1'b0, a} + {1'b0, b} + w_cin_ext;
                c_upd       = 1'b1;
            end
            // Top bit of the (WIDTH+1)-bit difference is the unsigned borrow.
            OP_SUB, OP_CMP: begin
                {c, result} = {1'b0, a} - {1'b0, b};
                c_upd       = 1'b1;
            end
            OP_SBB: begin
                {c, result} = {1'b0, a} - {1'b0, b} - w_cin_ext;
                c_upd       = 1'b1;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_MOV: result = a;
            // Extra guard bit catches the last bit shifted out; zero for amount 0.
            OP_SHL: begin
                {c, result} = {1'b0, a} << w_sh;
                c_upd       = 1'b1;
            end
            OP_SHR: begin
                {result, c} = {a, 1'b0} >> w_sh;
                c_upd       = 1'b1;
            end
            OP_SAR: begin
                {result, c} = $signed({a, 1'b0}) >>> w_sh;
                c_upd       = 1'b1;
            end
            // A shift by WIDTH yields zero, so amount 0 rotates to a unchanged.
            OP_ROL: result = (a << w_sh) | (a >> (32'(WIDTH) - w_sh));
            OP_ROR: result = (a >> w_sh) | (a << (32'(WIDTH) - w_sh));
            default: begin
                result = '0;
                c      = 1'b0;
                c_upd  = 1'b0;
            end
        endcase
    end

    assign n     = result[WIDTH-1];
    assign z     = (result == '0);
    assign wr_en = (op != OP_NOP) && (op != OP_CMP);

endmodule

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: 2-stage pipelined ALU with its own register file and PSW.
//   clk, rst            - clock, asynchronous active-high reset
//   instr_valid/ready   - instruction handshake; instr = {op, td, src1, src2}
//   ld_en/addr/data     - host register load (blocks instruction accept)
//   rd_addr/rd_data     - combinational debug read of the register file
//   res_valid/ready     - result handshake; res_data/res_addr = value/destination
//   psw                 - {N, Z, C}
// Stage X holds the accepted instruction with operands already read; the ALU
// evaluates from X and its result lands in the output register (stage O),
// the register file and the PSW on the same edge.
module alu_pipe_exec
    import alu_pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned AW    = 4,
    localparam int unsigned IW    = 4 + 3 * AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [IW-1:0]    instr,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [AW-1:0]    res_addr,
    output logic [2:0]       psw
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [2:0]       r_psw;

    logic             r_x_valid;
    op_t              r_x_op;
    logic [AW-1:0]    r_x_td;
    logic [WIDTH-1:0] r_x_a;
    logic [WIDTH-1:0] r_x_b;
    logic [AW-1:0]    r_x_sh;

    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [AW-1:0]    r_res_addr;

    op_t              w_op;
    logic [AW-1:0]    w_td;
    logic [AW-1:0]    w_src1;
    logic [AW-1:0]    w_src2;
    logic             w_o_stall;
    logic             w_x_adv;
    logic             w_x_res;
    logic             w_accept;
    logic             w_wb;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;

    logic [WIDTH-1:0] w_result;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_c_upd;
    logic             w_wr_en;

    assign w_op   = instr[IW-1 -: 4];
    assign w_td   = instr[3*AW-1 -: AW];
    assign w_src1 = instr[2*AW-1 -: AW];
    assign w_src2 = instr[AW-1:0];

    assign w_o_stall   = r_res_valid && !res_ready;
    assign w_x_adv     = r_x_valid && !w_o_stall;
    assign w_x_res     = (r_x_op != OP_NOP);
    assign w_wb        = w_x_adv && w_wr_en;
    assign instr_ready = !ld_en && !(r_x_valid && w_o_stall);
    assign w_accept    = instr_valid && instr_ready;

    // Bypass the writeback that lands on the same edge as this accept.
    assign w_opa = (w_wb && (r_x_td == w_src1)) ? w_result : r_regs[w_src1];
    assign w_opb = (w_wb && (r_x_td == w_src2)) ? w_result : r_regs[w_src2];

    // Carry-in comes from the live PSW: any older instruction has already
    // retired into it by the time this one evaluates.
    alu_pipe_core #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_core (
        .op     (r_x_op),
        .a      (r_x_a),
        .b      (r_x_b),
        .shamt  (r_x_sh),
        .cin    (r_psw[PSW_C]),
        .result (w_result),
        .n      (w_n),
        .z      (w_z),
        .c      (w_c),
        .c_upd  (w_c_upd),
        .wr_en  (w_wr_en)
    );

    // Register file: writeback is assigned last so it wins over a host load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                r_regs[ld_addr] <= ld_data;
            end
            if (w_wb) begin
                r_regs[r_x_td] <= w_result;
            end
        end
    end

    // Stage X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_valid <= 1'b0;
            r_x_op    <= OP_NOP;
            r_x_td    <= '0;
            r_x_a     <= '0;
            r_x_b     <= '0;
            r_x_sh    <= '0;
        end else if (w_accept) begin
            r_x_valid <= 1'b1;
            r_x_op    <= w_op;
            r_x_td    <= w_td;
            r_x_a     <= w_opa;
            r_x_b     <= w_opb;
            r_x_sh    <= w_src2;
        end else if (w_x_adv) begin
            r_x_valid <= 1'b0;
        end
    end

    // Stage O and PSW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_addr  <= '0;
            r_psw       <= 3'b000;
        end else begin
            if (!w_o_stall) begin
                r_res_valid <= w_x_adv && w_x_res;
                if (w_x_adv && w_x_res) begin
                    r_res_data <= w_result;
                    r_res_addr <= r_x_td;
                end
            end
            if (w_x_adv && w_x_res) begin
                r_psw[PSW_N] <= w_n;
                r_psw[PSW_Z] <= w_z;
                if (w_c_upd) begin
                    r_psw[PSW_C] <= w_c;
                end
            end
        end
    end

    assign rd_data   = r_regs[rd_addr];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_addr  = r_res_addr;
    assign psw       = r_psw;

endmodule

// File: tb/tb_alu_pipe_exec.sv
// Scoreboard bench for alu_pipe_exec (WIDTH=16, AW=4): stimulus pushes the
// hand-computed result/address/psw on accept; a negedge monitor pops and
// compares each result the DUT hands over.
module tb_alu_pipe_exec;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  addr;
        logic [2:0]  psw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [3:0]  res_addr;
    logic [2:0]  psw;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_pipe_exec #(
        .WIDTH (16),
        .AW    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_addr    (res_addr),
        .psw         (psw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the next posedge when valid&&ready here.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data 0x%0h addr %0d, expected none",
                         res_data, res_addr);
            end else begin
                e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_addr", 32'(res_addr), 32'(e.addr));
                chk("psw", 32'(psw), 32'(e.psw));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input logic has_res, input logic [15:0] d,
                         input logic [3:0] a, input logic [2:0] p);
        bit ok;
        ok          = 1'b0;
        instr_valid = 1'b1;
        instr       = ins;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            tick();
            return;
        end
        if (has_res) begin
            sb.push_back('{data: d, addr: a, psw: p});
        end
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic chk_reg(input logic [3:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        chk($sformatf("reg_r%0d", a), 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_psw", 32'(psw), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);

        // ADD overflow to zero
        load(4'd1, 16'hFFFF);
        load(4'd2, 16'h0001);
        issue(16'h1312, 1'b1, 16'h0000, 4'd3, 3'b011);
        drain();
        chk_reg(4'd3, 16'h0000);

        // Data + carry forwarding: clear C, seed r3 with a stale value first
        load(4'd3, 16'h1234);
        issue(16'h1522, 1'b1, 16'h0002, 4'd5, 3'b000);
        issue(16'h1312, 1'b1, 16'h0000, 4'd3, 3'b011);
        issue(16'hC432, 1'b1, 16'h0002, 4'd4, 3'b000);
        drain();
        chk_reg(4'd4, 16'h0002);

        // Shifts, rotates, logic, NOP
        load(4'd1, 16'h8001);
        issue(16'h7511, 1'b1, 16'h0002, 4'd5, 3'b001);
        issue(16'hB614, 1'b1, 16'h1800, 4'd6, 3'b001);
        issue(16'h2712, 1'b1, 16'h8000, 4'd7, 3'b100);
        issue(16'h9814, 1'b1, 16'hF800, 4'd8, 3'b100);
        issue(16'h6A10, 1'b1, 16'h7FFE, 4'd10, 3'b000);
        issue(16'h0000, 1'b0, 16'h0000, 4'd0, 3'b000);
        issue(16'hFB20, 1'b1, 16'h0001, 4'd11, 3'b000);
        issue(16'h7C10, 1'b1, 16'h8001, 4'd12, 3'b100);
        drain();
        chk_reg(4'd8, 16'hF800);
        chk_reg(4'd11, 16'h0001);
        chk_reg(4'd12, 16'h8001);

        // CMP: no register write
        load(4'd1, 16'h0001);
        load(4'd2, 16'h0002);
        load(4'd0, 16'h00AA);
        issue(16'hE012, 1'b1, 16'hFFFF, 4'd0, 3'b101);
        drain();
        chk_reg(4'd0, 16'h00AA);

        // Writeback beats a host load to the same index on the same edge
        issue(16'hFD20, 1'b1, 16'h0002, 4'd13, 3'b001);
        load(4'd13, 16'h5555);
        drain();
        chk_reg(4'd13, 16'h0002);

        // Backpressure: two accepted, third held off, data stable
        load(4'd1, 16'h0003);
        load(4'd2, 16'h0004);
        res_ready = 1'b0;
        issue(16'h1E12, 1'b1, 16'h0007, 4'd14, 3'b000);
        issue(16'h3F12, 1'b1, 16'h0000, 4'd15, 3'b010);
        instr_valid = 1'b1;
        instr       = 16'h4D12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_instr_ready", 32'(instr_ready), 32'd0);
            chk("stall_res_valid", 32'(res_valid), 32'd1);
            chk("stall_res_data", 32'(res_data), 32'h0007);
            chk("stall_res_addr", 32'(res_addr), 32'd14);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        issue(16'h4D12, 1'b1, 16'h0007, 4'd13, 3'b000);
        drain();
        chk_reg(4'd15, 16'h0000);

        // Reset mid-stream with a stalled result pending
        res_ready = 1'b0;
        issue(16'h1312, 1'b1, 16'h0000, 4'd3, 3'b000);
        tick();
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_psw", 32'(psw), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk_reg(4'(i), 16'h0000);
        end
        tick();
        rst       = 1'b0;
        res_ready = 1'b1;
        tick();
        load(4'd1, 16'h0005);
        load(4'd2, 16'h0003);
        issue(16'h1312, 1'b1, 16'h0008, 4'd3, 3'b000);
        drain();
        chk_reg(4'd3, 16'h0008);

        repeat (3) tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe_exec.md
Name: alu_pipe_exec

Overview:
- Parametrised, pipelined successor to the 16-bit combinational ALU.
- Owns a DEPTH-entry register file and a PSW register.
- Accepts packed instructions ({op, td, src1, src2}) over a valid/ready handshake, executes them in a 2-stage pipeline with operand forwarding, writes results back, and emits each result on a valid/ready output port.
- Sits between an instruction source (host/bench sequencer) and a result consumer.

Parameters:
- WIDTH, 16, data width of registers and results.
- AW, 4, register index width; DEPTH = 2**AW; also the width of the shift-amount field.
- IW, 4+3*AW, instruction width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  instruction accepted when valid&&ready at a clk edge.
- instr  in  IW  {op[3:0], td[AW-1:0], src1[AW-1:0], src2[AW-1:0]}.
- ld_en  in  1  host register load.
- ld_addr  in  AW  load index.
- ld_data  in  WIDTH  load value.
- rd_addr  in  AW  debug read index.
- rd_data  out  WIDTH  combinational regfile[rd_addr].
- res_valid  out  1  result held in output register.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  result value.
- res_addr  out  AW  destination index of the result.
- psw  out  3  {N, Z, C}.

Behaviour:
- Reset (async): regfile all 0, psw=3'b000, res_valid=0, res_data=0, res_addr=0, X stage invalid. Reset mid-operation discards in-flight work; the first post-reset accept works normally.
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 NOT(src1); 7 SHL; 8 SHR (logical); 9 SAR; 10 ROL; 11 ROR; 12 ADC; 13 SBB; 14 CMP; 15 MOV(src1).
  - For ops 7-11 the src2 field is an immediate shift amount, taken modulo WIDTH.
- Stage X (accept edge):
  - latches op and td, and reads operands regfile[src1] and regfile[src2].
  - Forwarding: if the instruction currently in X transfers on the same edge and writes the same index, the forwarded result is used instead of the regfile value.
  - ADC/SBB use the carry produced by that transferring instruction (forwarded PSW).
- Stage O (edge after accept, if O is free or res_ready=1):
  - result loaded into res_data/res_addr, res_valid=1.
  - regfile[td] written and psw updated on the same edge.
  - Latency: accept at edge N, result visible after edge N+1. Throughput 1/cycle.
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - C = carry-out for ADD/ADC; borrow (unsigned src1 < src2 [+C]) for SUB/SBB/CMP.
  - C = last bit shifted out for SHL/SHR/SAR, 0 when the amount is 0.
  - C unchanged for logic ops, NOT, MOV, ROL, ROR.
- CMP: updates psw, outputs the difference with res_valid=1, no regfile write.
- NOP: consumed; no result, no write, no psw change.
- Backpressure:
  - O is stalled when res_valid && !res_ready; X holds while stalled.
  - instr_ready = !ld_en && !(X valid && O stalled).
  - res_data/res_addr stay stable while stalled.
- Host load: ld_en writes regfile at the edge. If a writeback targets the same index on the same edge, the writeback wins.
- Arithmetic is modulo 2**WIDTH; no sign extension beyond WIDTH.

Decomposition:
- Package alu_pipe_pkg: opcode localparams (OP_NOP..OP_MOV) and PSW bit positions (PSW_N=2, PSW_Z=1, PSW_C=0).
- Sub-module alu_pipe_core: combinational, parametrised WIDTH. Inputs: op, a, b, shamt, cin. Outputs: result, N, Z, C, c_upd (C-update enable), wr_en.

Test Plan (WIDTH=16, AW=4):
- Reset: assert rst mid-stream -> res_valid=0, psw=000, rd_data=0 for all 16 indices; first instruction after release executes correctly.
- Load r1=0xFFFF, r2=0x0001; instr 0x1312 (ADD r3=r1+r2) -> res_data=0x0000, res_addr=3, psw=3'b011.
- Back-to-back 0x1312 then 0xC432 (ADC r4=r3+r2) -> r4=0x0002, confirming data and carry forwarding.
- r1=0x8001; 0x7511 (SHL by 1) -> 0x0002, C=1; 0xB614 (ROR by 4) -> 0x1800, C unchanged.
- CMP 0xE012 with r1=0x0001, r2=0x0002 -> res_data=0xFFFF, psw=3'b101, regfile[0] unchanged.
- Hold res_ready=0 and offer 3 instructions -> 2 accepted, instr_ready=0, res_data stable; release -> results delivered in order, no loss or duplication.
